// File: rtl/conv3x3_pe_pkg.sv
// Shared constants, loader state encoding and the output saturation helper
// for the 3x3 convolution processing element.
package conv_pkg;

    localparam int PIX_W     = 8;
    localparam int W_W       = 8;
    localparam int BIAS_W    = 16;
    localparam int PROD_W    = 17;
    localparam int COL_W     = 19;
    localparam int ACC_W     = 22;
    localparam int NUM_TAPS  = 9;
    localparam int CFG_BYTES = 11;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOAD = 1'b1
    } cfg_state_e;

    // Clamp a non-negative shifted accumulator to the 8-bit pixel range.
    function automatic logic [7:0] sat_u8(input logic [ACC_W:0] v);
        if (|v[ACC_W:8]) begin
            return 8'hFF;
        end else begin
            return v[7:0];
        end
    endfunction

endpackage

// File: rtl/conv3x3_pe_cfg_loader.sv
// Serial weight/bias loader: byte-wide shadow fill, atomic commit of the
// active set on the final bias byte, cfg_done pulse and sticky w_ready.
module conv3x3_cfg_loader
    import conv_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cfg_start,
    input  logic                          cfg_valid,
    input  logic [7:0]                    cfg_data,
    output logic                          cfg_done,
    output logic                          w_ready,
    output logic [NUM_TAPS-1:0][W_W-1:0]  act_w,
    output logic [BIAS_W-1:0]             act_bias
);

    cfg_state_e                   r_state;
    cfg_state_e                   w_next_state;
    logic [3:0]                   r_count;
    logic [NUM_TAPS-1:0][W_W-1:0] r_shadow_w;
    logic [7:0]                   r_shadow_bias_lo;
    logic [NUM_TAPS-1:0][W_W-1:0] r_act_w;
    logic [BIAS_W-1:0]            r_act_bias;
    logic                         r_done;
    logic                         r_ready;
    logic                         w_accept;
    logic                         w_commit;
    logic [3:0]                   w_slot;

    // Loader state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: a start pulse always wins and restarts the load.
    always_comb begin
        w_next_state = r_state;
        if (cfg_start) begin
            w_next_state = LOAD;
        end else if (w_commit) begin
            w_next_state = IDLE;
        end else begin
            w_next_state = r_state;
        end
    end

    // Byte acceptance decode; a byte alongside cfg_start lands in slot 0.
    always_comb begin
        w_slot = cfg_start ? 4'd0 : r_count;
        if (cfg_start) begin
            w_accept = cfg_valid;
        end else if (r_state == LOAD) begin
            w_accept = cfg_valid;
        end else begin
            w_accept = 1'b0;
        end
        w_commit = w_accept && (w_slot == 4'(CFG_BYTES - 1));
    end

    // Shadow fill, commit and status flags. Stale shadow bytes from an
    // aborted load are always overwritten before the next commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count          <= 4'd0;
            r_shadow_w       <= '0;
            r_shadow_bias_lo <= 8'd0;
            r_act_w          <= '0;
            r_act_bias       <= 16'd0;
            r_done           <= 1'b0;
            r_ready          <= 1'b0;
        end else begin
            r_done  <= w_commit;
            r_ready <= r_ready | w_commit;
            if (w_accept) begin
                r_count <= w_slot + 4'd1;
            end else if (cfg_start) begin
                r_count <= 4'd0;
            end
            if (w_accept && (w_slot < 4'(NUM_TAPS))) begin
                r_shadow_w[w_slot] <= cfg_data;
            end
            if (w_accept && (w_slot == 4'(NUM_TAPS))) begin
                r_shadow_bias_lo <= cfg_data;
            end
            if (w_commit) begin
                r_act_w    <= r_shadow_w;
                r_act_bias <= {cfg_data, r_shadow_bias_lo};
            end
        end
    end

    assign cfg_done = r_done;
    assign w_ready  = r_ready;
    assign act_w    = r_act_w;
    assign act_bias = r_act_bias;

endmodule

// File: rtl/conv3x3_pe.sv
// 3x3 convolution PE: 4-cycle MAC pipeline with ReLU, shift and saturation.
// Optional macro CONV3X3_PE_ROUND_EN selects round-half-up before the shift.
module conv3x3_pe #(
    parameter int OUT_SHIFT = 7,
    parameter int PIX_W     = 8,
    parameter int W_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             win_valid,
    input  logic [PIX_W-1:0] win_0,
    input  logic [PIX_W-1:0] win_1,
    input  logic [PIX_W-1:0] win_2,
    input  logic [PIX_W-1:0] win_3,
    input  logic [PIX_W-1:0] win_4,
    input  logic [PIX_W-1:0] win_5,
    input  logic [PIX_W-1:0] win_6,
    input  logic [PIX_W-1:0] win_7,
    input  logic [PIX_W-1:0] win_8,
    input  logic             cfg_start,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_data,
    output logic             cfg_done,
    output logic             w_ready,
    output logic             out_valid,
    output logic [7:0]       out_pixel
);
    import conv_pkg::*;

`ifdef CONV3X3_PE_ROUND_EN
    localparam logic [ACC_W:0] ROUND_ADD = ({{ACC_W{1'b0}}, 1'b1} << OUT_SHIFT) >> 1;
`else
    localparam logic [ACC_W:0] ROUND_ADD = '0;
`endif

    logic [NUM_TAPS-1:0][W_W-1:0]   w_act_w;
    logic [BIAS_W-1:0]              w_act_bias;
    logic [NUM_TAPS-1:0][PIX_W-1:0] w_win;

    logic                           r_s1_valid;
    logic [NUM_TAPS-1:0][PIX_W-1:0] r_s1_pix;
    logic [NUM_TAPS-1:0][W_W-1:0]   r_s1_w;
    logic [BIAS_W-1:0]              r_s1_bias;
    logic signed [PROD_W-1:0]       w_prod [NUM_TAPS];
    logic                           r_s2_valid;
    logic signed [PROD_W-1:0]       r_s2_prod [NUM_TAPS];
    logic [BIAS_W-1:0]              r_s2_bias;
    logic                           r_s3_valid;
    logic signed [COL_W-1:0]        r_s3_col [3];
    logic [BIAS_W-1:0]              r_s3_bias;
    logic                           r_s4_valid;
    logic signed [ACC_W-1:0]        r_s4_acc;
    logic [ACC_W:0]                 w_pos;
    logic [7:0]                     w_pix_next;
    logic                           r_out_valid;
    logic [7:0]                     r_out_pixel;

    conv3x3_cfg_loader u_cfg (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .cfg_valid (cfg_valid),
        .cfg_data  (cfg_data),
        .cfg_done  (cfg_done),
        .w_ready   (w_ready),
        .act_w     (w_act_w),
        .act_bias  (w_act_bias)
    );

    assign w_win = {win_8, win_7, win_6, win_5, win_4, win_3, win_2, win_1, win_0};

    // Unsigned pixel times signed weight, both extended to the product width.
    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            w_prod[k] = $signed({{(PROD_W-PIX_W){1'b0}}, r_s1_pix[k]})
                      * $signed({{(PROD_W-W_W){r_s1_w[k][W_W-1]}}, r_s1_w[k]});
        end
    end

    // Post-ReLU requantisation of the accumulator.
    always_comb begin
        w_pos      = '0;
        w_pix_next = 8'd0;
        if (r_s4_acc[ACC_W-1]) begin
            w_pix_next = 8'd0;
        end else begin
            w_pos      = ({1'b0, r_s4_acc} + ROUND_ADD) >> OUT_SHIFT;
            w_pix_next = sat_u8(w_pos);
        end
    end

    // Pipeline: the weight set travels with its window from capture onwards.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_pix    <= '0;
            r_s1_w      <= '0;
            r_s1_bias   <= '0;
            r_s2_valid  <= 1'b0;
            r_s2_bias   <= '0;
            r_s3_valid  <= 1'b0;
            r_s3_bias   <= '0;
            r_s4_valid  <= 1'b0;
            r_s4_acc    <= '0;
            r_out_valid <= 1'b0;
            r_out_pixel <= 8'd0;
            for (int k = 0; k < NUM_TAPS; k++) r_s2_prod[k] <= '0;
            for (int c = 0; c < 3; c++) r_s3_col[c] <= '0;
        end else begin
            r_s1_valid <= win_valid && w_ready;
            r_s1_pix   <= w_win;
            r_s1_w     <= w_act_w;
            r_s1_bias  <= w_act_bias;
            r_s2_valid <= r_s1_valid;
            r_s2_bias  <= r_s1_bias;
            for (int k = 0; k < NUM_TAPS; k++) r_s2_prod[k] <= w_prod[k];
            r_s3_valid <= r_s2_valid;
            r_s3_bias  <= r_s2_bias;
            for (int c = 0; c < 3; c++) begin
                r_s3_col[c] <= COL_W'(r_s2_prod[3*c]) + COL_W'(r_s2_prod[3*c+1])
                             + COL_W'(r_s2_prod[3*c+2]);
            end
            r_s4_valid <= r_s3_valid;
            r_s4_acc   <= ACC_W'(r_s3_col[0]) + ACC_W'(r_s3_col[1]) + ACC_W'(r_s3_col[2])
                        + ACC_W'($signed(r_s3_bias));
            r_out_valid <= r_s4_valid;
            if (r_s4_valid) begin
                r_out_pixel <= w_pix_next;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_pixel = r_out_pixel;

endmodule

// File: tb/tb_conv3x3_pe.sv
// Self-checking bench for conv3x3_pe: cycle-accurate scoreboard plus
// per-scenario directed checks.
module tb_conv3x3_pe;

    localparam int SHIFT = 7;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       win_valid = 1'b0;
    logic [7:0] win [9];
    logic       cfg_start = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_data = 8'd0;
    logic       cfg_done, w_ready, out_valid;
    logic [7:0] out_pixel;

    always #5 clk = ~clk;

    conv3x3_pe dut (
        .clk(clk), .rst_n(rst_n), .win_valid(win_valid),
        .win_0(win[0]), .win_1(win[1]), .win_2(win[2]), .win_3(win[3]), .win_4(win[4]),
        .win_5(win[5]), .win_6(win[6]), .win_7(win[7]), .win_8(win[8]),
        .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
        .cfg_done(cfg_done), .w_ready(w_ready), .out_valid(out_valid), .out_pixel(out_pixel)
    );

    typedef struct { int due; logic [7:0] pix; } exp_t;
    exp_t sb_q[$];

    int total = 0, bad = 0, cyc = 0, done_cnt = 0, ov_cnt = 0;

    // reference model of the committed/shadow sets
    logic [7:0]  m_w [9];
    logic [7:0]  m_sw [9];
    logic [7:0]  m_blo;
    logic [15:0] m_bias;
    bit          m_ready = 1'b0, m_load = 1'b0;
    int          m_cnt = 0;

    function automatic logic [7:0] ref_pix(input int acc);
        int v;
        if (acc < 0) return 8'd0;
        v = acc;
`ifdef CONV3X3_PE_ROUND_EN
        v = v + (1 << (SHIFT - 1));
`endif
        v = v >>> SHIFT;
        if (v > 255) return 8'd255;
        return 8'(v);
    endfunction

    task automatic tick();
        int acc, slot;
        bit acc_ok, exp_v;
        exp_t e;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            sb_q.delete();
            m_ready = 1'b0; m_load = 1'b0; m_cnt = 0; m_bias = 16'd0; m_blo = 8'd0;
            for (int k = 0; k < 9; k++) begin m_w[k] = 8'd0; m_sw[k] = 8'd0; end
        end else begin
            if (win_valid && m_ready) begin
                acc = int'($signed(m_bias));
                for (int k = 0; k < 9; k++) acc += int'($signed(m_w[k])) * int'(win[k]);
                e.due = cyc + 4; e.pix = ref_pix(acc);
                sb_q.push_back(e);
            end
            slot   = cfg_start ? 0 : m_cnt;
            acc_ok = cfg_valid && (cfg_start || m_load);
            if (cfg_start) begin m_load = 1'b1; m_cnt = 0; end
            if (acc_ok) begin
                if (slot < 9) m_sw[slot] = cfg_data;
                else if (slot == 9) m_blo = cfg_data;
                else begin
                    m_w = m_sw; m_bias = {cfg_data, m_blo}; m_ready = 1'b1; m_load = 1'b0;
                end
                m_cnt = slot + 1;
            end
        end
        @(negedge clk);
        if (cfg_done === 1'b1) done_cnt++;
        if (out_valid === 1'b1) ov_cnt++;
        while (sb_q.size() > 0 && sb_q[0].due < cyc) void'(sb_q.pop_front());
        exp_v = (sb_q.size() > 0) && (sb_q[0].due == cyc);
        total++;
        if (out_valid !== exp_v) begin
            bad++;
            $display("FAIL sb_valid cyc=%0d got=%b want=%b", cyc, out_valid, exp_v);
        end
        if (exp_v) begin
            e = sb_q.pop_front();
            total++;
            if (out_pixel !== e.pix) begin
                bad++;
                $display("FAIL sb_pixel cyc=%0d got=%0d want=%0d", cyc, out_pixel, e.pix);
            end
        end
    endtask

    task automatic set_win(input logic [7:0] v);
        for (int k = 0; k < 9; k++) win[k] = v;
    endtask

    task automatic send_win(input logic [7:0] v);
        set_win(v); win_valid = 1'b1; tick(); win_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; win_valid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic load_set(input logic [7:0] w, input logic [15:0] bias);
        for (int b = 0; b < 11; b++) begin
            cfg_start = (b == 0); cfg_valid = 1'b1;
            cfg_data  = (b < 9) ? w : ((b == 9) ? bias[7:0] : bias[15:8]);
            tick();
        end
        cfg_start = 1'b0; cfg_valid = 1'b0;
        total++;
        if (cfg_done !== 1'b1 || w_ready !== 1'b1) begin
            bad++; $display("FAIL load_commit got done=%b ready=%b want 1 1", cfg_done, w_ready);
        end
        tick();
        total++;
        if (cfg_done !== 1'b0) begin
            bad++; $display("FAIL load_done_pulse got=%b want=0", cfg_done);
        end
    endtask

    task automatic expect_pix(input string name, input logic [7:0] want);
        total++;
        if (out_valid !== 1'b1 || out_pixel !== want) begin
            bad++; $display("FAIL %s got v=%b pix=%0d want v=1 pix=%0d", name, out_valid, out_pixel, want);
        end
    endtask

    task automatic test_reset();
        set_win(8'd0);
        do_reset();
        total++;
        if (out_valid !== 1'b0 || out_pixel !== 8'd0 || cfg_done !== 1'b0 || w_ready !== 1'b0) begin
            bad++; $display("FAIL reset_state got v=%b pix=%0d done=%b ready=%b want 0 0 0 0",
                            out_valid, out_pixel, cfg_done, w_ready);
        end
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        load_set(8'h01, 16'h0000);
        repeat (3) tick();
        total++;
        if (done_cnt != d0 + 1) begin
            bad++; $display("FAIL done_once got=%0d want=%0d", done_cnt - d0, 1);
        end
        send_win(8'd128);
        repeat (4) tick();
        expect_pix("basic_9", 8'd9);
        tick();
        total++;
        if (out_valid !== 1'b0 || out_pixel !== 8'd9) begin
            bad++; $display("FAIL hold got v=%b pix=%0d want v=0 pix=9", out_valid, out_pixel);
        end
    endtask

    task automatic test_relu_sat();
        load_set(8'hFF, 16'h0000);
        send_win(8'd128); repeat (4) tick();
        expect_pix("relu_0", 8'd0);
        load_set(8'h7F, 16'h0000);
        send_win(8'd255); repeat (4) tick();
        expect_pix("sat_255", 8'd255);
    endtask

    task automatic test_bias();
        load_set(8'h00, 16'h0280);
        send_win(8'd77); repeat (4) tick();
        expect_pix("bias_640", 8'd5);
        load_set(8'h00, 16'h00C0);
        send_win(8'd33); repeat (4) tick();
`ifdef CONV3X3_PE_ROUND_EN
        expect_pix("bias_192", 8'd2);
`else
        expect_pix("bias_192", 8'd1);
`endif
    endtask

    task automatic test_no_weights();
        int ov0;
        do_reset();
        ov0 = ov_cnt;
        for (int i = 0; i < 10; i++) send_win(8'(i * 25 + 3));
        repeat (6) tick();
        total++;
        if (ov_cnt != ov0 || w_ready !== 1'b0) begin
            bad++; $display("FAIL no_weights got outs=%0d ready=%b want 0 0", ov_cnt - ov0, w_ready);
        end
    endtask

    task automatic test_back_to_back();
        int n9 = 0, n18 = 0, nother = 0;
        load_set(8'h01, 16'h0000);
        set_win(8'd128);
        for (int i = 0; i < 40; i++) begin
            win_valid = 1'b1;
            cfg_start = (i == 10);
            cfg_valid = (i >= 10 && i <= 20);
            cfg_data  = (i < 19) ? 8'h02 : 8'h00;
            tick();
            if (out_valid === 1'b1) begin
                if (out_pixel === 8'd9) n9++;
                else if (out_pixel === 8'd18) n18++;
                else nother++;
            end
        end
        win_valid = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0;
        total++;
        if (n9 != 21 || n18 != 15 || nother != 0) begin
            bad++; $display("FAIL swap_counts got n9=%0d n18=%0d other=%0d want 21 15 0", n9, n18, nother);
        end
        repeat (6) tick();
    endtask

    task automatic test_restart_and_reset();
        int d0, ov0;
        load_set(8'h01, 16'h0000);
        d0 = done_cnt;
        for (int b = 0; b < 5; b++) begin
            cfg_start = (b == 0); cfg_valid = 1'b1; cfg_data = 8'h05; tick();
        end
        cfg_start = 1'b1; cfg_valid = 1'b0; tick();
        cfg_start = 1'b0;
        for (int b = 0; b < 11; b++) begin
            cfg_valid = 1'b1; cfg_data = (b < 9) ? 8'h03 : 8'h00; tick();
        end
        cfg_valid = 1'b0;
        tick();
        total++;
        if (done_cnt != d0 + 1) begin
            bad++; $display("FAIL restart_done got=%0d want=1", done_cnt - d0);
        end
        send_win(8'd128); repeat (4) tick();
        expect_pix("restart_27", 8'd27);
        ov0 = ov_cnt;
        set_win(8'd200); win_valid = 1'b1;
        repeat (3) tick();
        win_valid = 1'b0;
        do_reset();
        repeat (8) tick();
        total++;
        if (ov_cnt != ov0 || w_ready !== 1'b0 || out_pixel !== 8'd0) begin
            bad++; $display("FAIL flush got outs=%0d ready=%b pix=%0d want 0 0 0",
                            ov_cnt - ov0, w_ready, out_pixel);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_relu_sat();
        test_bias();
        test_no_weights();
        test_back_to_back();
        test_restart_and_reset();
        repeat (6) tick();
        total++;
        if (sb_q.size() != 0) begin
            bad++; $display("FAIL sb_drain got=%0d pending want=0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
